// File: rtl/nms_hls_deadlock_report_unit_if.sv
// Signal bundle between the deadlock-report unit and its driver/reader.
// The unit is the slave; the side that drives the monitor inputs is the master.
interface nms_hls_deadlock_report_unit_if #(
    parameter int THRESHOLD = 1024,
    parameter int CNT_W     = 32,
    parameter int EP_W      = 8
);
    localparam int RUN_W = $clog2(THRESHOLD + 1);

    logic             monitor_en;
    logic             block_in;
    logic             clear;
    logic             deadlock;
    logic             in_wait;
    logic [RUN_W-1:0] run_cnt;
    logic [EP_W-1:0]  episode_cnt;
    logic [CNT_W-1:0] deadlock_cycle;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output monitor_en, block_in, clear,
        input  deadlock, in_wait, run_cnt, episode_cnt, deadlock_cycle, cycle_cnt
    );

    modport slave (
        input  monitor_en, block_in, clear,
        output deadlock, in_wait, run_cnt, episode_cnt, deadlock_cycle, cycle_cnt
    );
endinterface

// File: rtl/nms_hls_deadlock_report_unit.sv
// Filters the deadlock monitor's block signal into a sticky, timestamped deadlock report
// and counts sub-threshold block episodes for PS-side debug readout.
module nms_hls_deadlock_report_unit #(
    parameter int THRESHOLD = 1024,
    parameter int CNT_W     = 32,
    parameter int EP_W      = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    nms_hls_deadlock_report_unit_if.slave  rpt
);
    localparam int RUN_W = $clog2(THRESHOLD + 1);
    localparam logic [RUN_W-1:0] THR_R = RUN_W'(THRESHOLD);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT     = 2'd1,
        ST_DEADLOCK = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [EP_W-1:0]  ep_q, ep_d;
    logic [CNT_W-1:0] dc_q, dc_d;
    logic [CNT_W-1:0] cycle_q;
    logic [RUN_W-1:0] run_inc;
    logic             hit;

    function automatic logic [EP_W-1:0] sat_inc_ep(input logic [EP_W-1:0] v);
        return (&v) ? v : v + EP_W'(1);
    endfunction

    assign hit     = rpt.monitor_en & rpt.block_in;
    assign run_inc = run_q + RUN_W'(1);

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        ep_d    = ep_q;
        dc_d    = dc_q;
        // clear wins over any hit sampled on the same edge
        if (rpt.clear) begin
            state_d = ST_IDLE;
            run_d   = '0;
            ep_d    = '0;
            dc_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hit) begin
                        run_d = RUN_W'(1);
                        if (THRESHOLD == 1) begin
                            state_d = ST_DEADLOCK;
                            dc_d    = cycle_q;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (hit) begin
                        run_d = run_inc;
                        if (run_inc == THR_R) begin
                            state_d = ST_DEADLOCK;
                            dc_d    = cycle_q;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        run_d   = '0;
                        ep_d    = sat_inc_ep(ep_q);
                    end
                end
                ST_DEADLOCK: begin
                    run_d = THR_R;
                end
                default: begin
                    state_d = ST_IDLE;
                    run_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            run_q   <= '0;
            ep_q    <= '0;
            dc_q    <= '0;
            cycle_q <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            ep_q    <= ep_d;
            dc_q    <= dc_d;
            cycle_q <= cycle_q + CNT_W'(1);
        end
    end

    assign rpt.deadlock       = (state_q == ST_DEADLOCK);
    assign rpt.in_wait        = (state_q == ST_WAIT);
    assign rpt.run_cnt        = run_q;
    assign rpt.episode_cnt    = ep_q;
    assign rpt.deadlock_cycle = dc_q;
    assign rpt.cycle_cnt      = cycle_q;
endmodule

// File: tb/tb_nms_hls_deadlock_report_unit.sv
// Scoreboard bench: directed vectors push expected post-edge outputs; a negedge monitor pops and compares.
// Two builds share clock/reset: THRESHOLD=4 (dut4) and THRESHOLD=1 (dut1).
module tb_nms_hls_deadlock_report_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   tb_edge = 0;
    int   errors = 0;
    int   checks = 0;
    int   exp_cyc = 0;

    typedef struct {
        int edge_no;
        bit sel;
        int dl, wt, rc, ep, dc, cc;
    } exp_t;

    exp_t sb[$];

    nms_hls_deadlock_report_unit_if #(.THRESHOLD(4), .CNT_W(32), .EP_W(2)) if4 ();
    nms_hls_deadlock_report_unit_if #(.THRESHOLD(1), .CNT_W(32), .EP_W(2)) if1 ();

    nms_hls_deadlock_report_unit #(.THRESHOLD(4), .CNT_W(32), .EP_W(2)) dut4 (
        .clock (clock),
        .reset (reset),
        .rpt   (if4)
    );

    nms_hls_deadlock_report_unit #(.THRESHOLD(1), .CNT_W(32), .EP_W(2)) dut1 (
        .clock (clock),
        .reset (reset),
        .rpt   (if1)
    );

    always #5 clock = ~clock;

    always @(posedge clock) tb_edge <= tb_edge + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, req, tb_edge);
        end
    endtask

    // Monitor: compare every entry whose target edge has just occurred.
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].edge_no == tb_edge) begin
            exp_t e;
            e = sb.pop_front();
            if (e.sel) begin
                chk("t1_deadlock",       int'(if1.deadlock),       e.dl);
                chk("t1_in_wait",        int'(if1.in_wait),        e.wt);
                chk("t1_run_cnt",        int'(if1.run_cnt),        e.rc);
                chk("t1_episode_cnt",    int'(if1.episode_cnt),    e.ep);
                chk("t1_deadlock_cycle", int'(if1.deadlock_cycle), e.dc);
                chk("t1_cycle_cnt",      int'(if1.cycle_cnt),      e.cc);
            end else begin
                chk("deadlock",       int'(if4.deadlock),       e.dl);
                chk("in_wait",        int'(if4.in_wait),        e.wt);
                chk("run_cnt",        int'(if4.run_cnt),        e.rc);
                chk("episode_cnt",    int'(if4.episode_cnt),    e.ep);
                chk("deadlock_cycle", int'(if4.deadlock_cycle), e.dc);
                chk("cycle_cnt",      int'(if4.cycle_cnt),      e.cc);
            end
        end
    end

    // Apply one edge's inputs and push the outputs expected after that edge.
    task automatic step(input bit sel, input logic rst, input logic en, input logic blk,
                        input logic clr, input int dl, input int wt, input int rc,
                        input int ep, input int dc);
        exp_t e;
        reset = rst;
        if4.monitor_en = sel ? 1'b0 : en;
        if4.block_in   = sel ? 1'b0 : blk;
        if4.clear      = sel ? 1'b0 : clr;
        if1.monitor_en = sel ? en  : 1'b0;
        if1.block_in   = sel ? blk : 1'b0;
        if1.clear      = sel ? clr : 1'b0;
        exp_cyc = rst ? 0 : exp_cyc + 1;
        e.edge_no = tb_edge + 1;
        e.sel = sel;
        e.dl = dl; e.wt = wt; e.rc = rc; e.ep = ep; e.dc = dc; e.cc = exp_cyc;
        sb.push_back(e);
        @(negedge clock);
        #1;
    endtask

    initial begin
        int ep_prev;
        int ep_after[5];
        ep_after = '{2, 3, 3, 3, 3};
        if4.monitor_en = 1'b0; if4.block_in = 1'b0; if4.clear = 1'b0;
        if1.monitor_en = 1'b0; if1.block_in = 1'b0; if1.clear = 1'b0;
        @(negedge clock);
        #1;

        // Reset state, then 10 idle edges (cycle_cnt reaches 10)
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (10) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Transient run of 3, then drop
        step(0, 0, 1, 1, 0, 0, 1, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0, 1, 2, 0, 0);
        step(0, 0, 1, 1, 0, 0, 1, 3, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 1, 0);

        // Idle until cycle_cnt=20, then confirm deadlock over edges 20..23
        repeat (6) step(0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 0, 0, 1, 1, 1, 0);
        step(0, 0, 1, 1, 0, 0, 1, 2, 1, 0);
        step(0, 0, 1, 1, 0, 0, 1, 3, 1, 0);
        step(0, 0, 1, 1, 0, 1, 0, 4, 1, 23);
        step(0, 0, 1, 0, 0, 1, 0, 4, 1, 23);
        step(0, 0, 0, 1, 0, 1, 0, 4, 1, 23);

        // Clear with block still high; new run starts one edge later
        step(0, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0, 1, 0);

        // Five 2-cycle transient runs: episode_cnt saturates at 3
        ep_prev = 1;
        for (int k = 0; k < 5; k++) begin
            step(0, 0, 1, 1, 0, 0, 1, 1, ep_prev, 0);
            step(0, 0, 1, 1, 0, 0, 1, 2, ep_prev, 0);
            step(0, 0, 1, 0, 0, 0, 0, 0, ep_after[k], 0);
            ep_prev = ep_after[k];
        end

        // monitor_en low masks block_in; dropping it during WAIT ends the episode
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        repeat (10) step(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 0, 0, 1, 1, 0, 0);
        step(0, 0, 1, 1, 0, 0, 1, 2, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0, 1, 0);

        // Reset mid-run clears everything including cycle_cnt
        step(0, 0, 1, 1, 0, 0, 1, 1, 1, 0);
        step(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);

        // THRESHOLD=1 build: hit at cycle_cnt=7 goes straight to DEADLOCK
        repeat (7) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0, 1, 0, 1, 0, 7);
        step(1, 0, 1, 1, 0, 1, 0, 1, 0, 7);
        step(1, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int w = 0; w < 20 && sb.size() > 0; w++) @(negedge clock);
        if (sb.size() > 0) begin
            chk("scoreboard_drain", sb.size(), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
